// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader.
//   state_e            : loader / CPU-control state encoding
//   CPU_RST_CYCLES_DEF : default length of the CPU reset pulse
//   HDR_LEN            : header length in bytes (addr_hi, addr_lo, cnt_hi, cnt_lo)
package prog_loader_pkg;

  localparam int unsigned CPU_RST_CYCLES_DEF = 9;
  localparam int unsigned HDR_LEN            = 4;

  // Order matters: the helpers below rely on the byte-accepting states
  // coming first, followed by WRITE.
  typedef enum logic [3:0] {
    ADDR_HI,
    ADDR_LO,
    CNT_HI,
    CNT_LO,
    DATA_HI,
    DATA_LO,
    WRITE,
    CPU_RST,
    RUN,
    HALT
  } state_e;

  // States in which a stream byte may be accepted.
  function automatic logic accepts_byte(input state_e s);
    return (s <= DATA_LO);
  endfunction

  // States in which the external port owns the CPU memory.
  function automatic logic owns_memory(input state_e s);
    return (s <= WRITE);
  endfunction

endpackage

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream (addr_hi, addr_lo, cnt_hi, cnt_lo,
// then cnt 16-bit words hi/lo), writes the words into CPU memory through the
// external port, then pulses the CPU reset for CPU_RST_CYCLES cycles, lets
// the CPU run and latches its halt indication.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   in_valid/in_data/in_ready  byte stream handshake
//   ext_we/ext_addr/ext_data   memory write port (addr/data hold when idle)
//   test_normal             1 = external port owns memory
//   cpu_rst_n               active-low CPU reset
//   done                    CPU halt indication (only observed in RUN)
//   halted                  sticky program-finished flag
//   words_loaded            words written in the current load
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CPU_RST_CYCLES = CPU_RST_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [15:0] ext_data,
  output logic        test_normal,
  output logic        cpu_rst_n,
  input  logic        done,
  output logic        halted,
  output logic [15:0] words_loaded
);

  // Header bytes preceding cnt_lo; cnt_lo is combined straight from in_data.
  localparam int unsigned HW       = (HDR_LEN - 1) * 8;
  localparam logic [15:0] RST_LAST = 16'(CPU_RST_CYCLES - 1);

  state_e         state_q, state_d;
  logic [HW-1:0]  hdr_q, hdr_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [15:0]    addr_q, addr_d;
  logic [15:0]    words_q, words_d;
  logic [7:0]     hi_q, hi_d;
  logic [15:0]    rst_cnt_q, rst_cnt_d;
  logic           we_d;
  logic [15:0]    ext_addr_q, ext_addr_d;
  logic [15:0]    ext_data_q, ext_data_d;
  logic           in_ready_q, ext_we_q, test_normal_q, cpu_rst_n_q, halted_q;
  logic           accept;

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    words_d    = words_q;
    hi_d       = hi_q;
    rst_cnt_d  = rst_cnt_q;
    we_d       = 1'b0;
    ext_addr_d = ext_addr_q;
    ext_data_d = ext_data_q;
    unique case (state_q)
      ADDR_HI: if (accept) begin
        hdr_d   = {hdr_q[HW-9:0], in_data};
        state_d = ADDR_LO;
      end
      ADDR_LO: if (accept) begin
        hdr_d   = {hdr_q[HW-9:0], in_data};
        state_d = CNT_HI;
      end
      CNT_HI: if (accept) begin
        hdr_d   = {hdr_q[HW-9:0], in_data};
        state_d = CNT_LO;
      end
      CNT_LO: if (accept) begin
        addr_d    = hdr_q[HW-1 -: 16];
        cnt_d     = {hdr_q[7:0], in_data};
        words_d   = '0;
        rst_cnt_d = '0;
        state_d   = ({hdr_q[7:0], in_data} != 16'd0) ? DATA_HI : CPU_RST;
      end
      DATA_HI: if (accept) begin
        hi_d    = in_data;
        state_d = DATA_LO;
      end
      DATA_LO: if (accept) begin
        // Write port is registered, so the strobe lands in the WRITE state.
        we_d       = 1'b1;
        ext_addr_d = addr_q;
        ext_data_d = {hi_q, in_data};
        state_d    = WRITE;
      end
      WRITE: begin
        addr_d    = addr_q + 16'd1;
        words_d   = words_q + 16'd1;
        rst_cnt_d = '0;
        state_d   = (words_d < cnt_q) ? DATA_HI : CPU_RST;
      end
      CPU_RST: begin
        if (rst_cnt_q == RST_LAST) state_d = RUN;
        else                       rst_cnt_d = rst_cnt_q + 16'd1;
      end
      RUN:  if (done) state_d = HALT;
      HALT: state_d = HALT;
      default: state_d = ADDR_HI;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= ADDR_HI;
      hdr_q         <= '0;
      cnt_q         <= '0;
      addr_q        <= '0;
      words_q       <= '0;
      hi_q          <= '0;
      rst_cnt_q     <= '0;
      ext_we_q      <= 1'b0;
      ext_addr_q    <= '0;
      ext_data_q    <= '0;
      in_ready_q    <= 1'b0;
      test_normal_q <= 1'b1;
      cpu_rst_n_q   <= 1'b0;
      halted_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      words_q       <= words_d;
      hi_q          <= hi_d;
      rst_cnt_q     <= rst_cnt_d;
      ext_we_q      <= we_d;
      ext_addr_q    <= ext_addr_d;
      ext_data_q    <= ext_data_d;
      in_ready_q    <= accepts_byte(state_d);
      test_normal_q <= owns_memory(state_d);
      cpu_rst_n_q   <= (state_d == RUN) || (state_d == HALT);
      halted_q      <= (state_d == HALT);
    end
  end

  assign in_ready     = in_ready_q;
  assign ext_we       = ext_we_q;
  assign ext_addr     = ext_addr_q;
  assign ext_data     = ext_data_q;
  assign test_normal  = test_normal_q;
  assign cpu_rst_n    = cpu_rst_n_q;
  assign halted       = halted_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, address wrap, empty load,
// stream gaps, done handling and mid-load reset.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        done = 1'b0;
  logic        in_ready, ext_we, test_normal, cpu_rst_n, halted;
  logic [15:0] ext_addr, ext_data, words_loaded;

  prog_loader #(.CPU_RST_CYCLES(9)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ext_we(ext_we), .ext_addr(ext_addr), .ext_data(ext_data),
    .test_normal(test_normal), .cpu_rst_n(cpu_rst_n), .done(done),
    .halted(halted), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Write monitor (samples on the falling edge).
  logic [15:0] wa[$];
  logic [15:0] wd[$];
  logic [15:0] ea[$];
  logic [15:0] ed[$];
  logic [15:0] stim[$];
  int   long_pulse = 0;
  int   hold_err = 0;
  logic we_prev = 1'b0;
  logic rst_prev = 1'b0;
  logic [15:0] la = '0, ld = '0;

  always @(negedge clk) begin
    if (ext_we) begin
      wa.push_back(ext_addr);
      wd.push_back(ext_data);
      if (we_prev) long_pulse++;
    end else if (reset_n && rst_prev && (ext_addr !== la || ext_data !== ld)) begin
      hold_err++;
    end
    we_prev  = ext_we;
    rst_prev = reset_n;
    la       = ext_addr;
    ld       = ext_data;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit hs;
    int n;
    if (gaps) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
    end
    in_valid = 1'b1;
    in_data  = b;
    hs = 1'b0;
    n  = 0;
    while (!hs && n < 40) begin
      hs = in_ready;
      tick();
      n++;
    end
    chk("byte_accepted", {31'd0, hs}, 32'd1);
  endtask

  // Header then all words in stim.
  task automatic send_load(input logic [15:0] addr, input bit gaps);
    logic [15:0] cnt;
    cnt = 16'(stim.size());
    send_byte(addr[15:8], gaps);
    send_byte(addr[7:0], gaps);
    send_byte(cnt[15:8], gaps);
    send_byte(cnt[7:0], gaps);
    foreach (stim[i]) begin
      send_byte(stim[i][15:8], gaps);
      send_byte(stim[i][7:0], gaps);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    in_valid = 1'b0;
    done     = 1'b0;
    tick();
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"},    {31'd0, in_ready},    32'd0);
    chk({tag, "_ext_we"},      {31'd0, ext_we},      32'd0);
    chk({tag, "_ext_addr"},    {16'd0, ext_addr},    32'd0);
    chk({tag, "_ext_data"},    {16'd0, ext_data},    32'd0);
    chk({tag, "_words"},       {16'd0, words_loaded}, 32'd0);
    chk({tag, "_test_normal"}, {31'd0, test_normal}, 32'd1);
    chk({tag, "_cpu_rst_n"},   {31'd0, cpu_rst_n},   32'd0);
    chk({tag, "_halted"},      {31'd0, halted},      32'd0);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, "_count"}, 32'(wa.size()), 32'(ea.size()));
    foreach (ea[i]) begin
      if (i < wa.size()) begin
        chk($sformatf("%s_addr%0d", tag, i), {16'd0, wa[i]}, {16'd0, ea[i]});
        chk($sformatf("%s_data%0d", tag, i), {16'd0, wd[i]}, {16'd0, ed[i]});
      end
    end
  endtask

  // Waits for the CPU reset phase and returns how many cycles cpu_rst_n
  // stayed low after test_normal fell; optionally drives done meanwhile.
  task automatic measure_cpu_rst(input bit drive_done, output int lowc);
    int n;
    n = 0;
    while (test_normal !== 1'b0 && n < 100) begin
      tick();
      n++;
    end
    chk("test_normal_fell", {31'd0, test_normal}, 32'd0);
    chk("in_ready_in_cpu_rst", {31'd0, in_ready}, 32'd0);
    lowc = 0;
    while (cpu_rst_n === 1'b0 && lowc < 100) begin
      done = drive_done && (lowc < 4);
      tick();
      lowc++;
    end
    done = 1'b0;
  endtask

  task automatic fill_prog1();
    stim = '{16'h1025, 16'h0863, 16'hE000, 16'h1900, 16'h1A01, 16'hE020,
             16'hE040, 16'h0328, 16'hE060, 16'h032A, 16'hE060, 16'hE001};
    ea.delete();
    ed.delete();
    foreach (stim[i]) begin
      ea.push_back(16'(i));
      ed.push_back(stim[i]);
    end
  endtask

  initial begin
    int lowc;

    // Reset state.
    do_reset();
    check_reset_values("reset");
    reset_n = 1'b1;
    tick();
    chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // 12-word program at 0x0000, gap-free; done during CPU_RST ignored.
    fill_prog1();
    wa.delete(); wd.delete();
    send_load(16'h0000, 1'b0);
    measure_cpu_rst(1'b1, lowc);
    chk("p1_cpu_rst_len", 32'(lowc), 32'd9);
    check_writes("p1");
    chk("p1_words", {16'd0, words_loaded}, 32'd12);
    chk("p1_not_halted", {31'd0, halted}, 32'd0);
    tick();
    tick();
    chk("p1_still_running", {31'd0, halted}, 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("p1_halted", {31'd0, halted}, 32'd1);
    chk("p1_cpu_rst_n_halt", {31'd0, cpu_rst_n}, 32'd1);

    // Same program with random gaps: identical write sequence.
    do_reset();
    reset_n = 1'b1;
    wa.delete(); wd.delete();
    send_load(16'h0000, 1'b1);
    measure_cpu_rst(1'b0, lowc);
    chk("p1g_cpu_rst_len", 32'(lowc), 32'd9);
    check_writes("p1g");

    // Two words at 0x0025.
    do_reset();
    reset_n = 1'b1;
    wa.delete(); wd.delete();
    stim = '{16'h0047, 16'h0089};
    ea = '{16'h0025, 16'h0026};
    ed = '{16'h0047, 16'h0089};
    send_load(16'h0025, 1'b1);
    measure_cpu_rst(1'b0, lowc);
    check_writes("p2");
    chk("p2_words", {16'd0, words_loaded}, 32'd2);

    // Address wrap 0xFFFF -> 0x0000.
    do_reset();
    reset_n = 1'b1;
    wa.delete(); wd.delete();
    stim = '{16'hAAAA, 16'h5555};
    ea = '{16'hFFFF, 16'h0000};
    ed = '{16'hAAAA, 16'h5555};
    send_load(16'hFFFF, 1'b0);
    measure_cpu_rst(1'b0, lowc);
    check_writes("wrap");
    chk("wrap_last_addr", {16'd0, ext_addr}, 32'h0000);
    chk("wrap_last_data", {16'd0, ext_data}, 32'h5555);

    // Empty load: straight to CPU_RST, then done / sticky halt.
    do_reset();
    reset_n = 1'b1;
    wa.delete(); wd.delete();
    stim.delete();
    ea.delete(); ed.delete();
    send_load(16'h0010, 1'b0);
    measure_cpu_rst(1'b0, lowc);
    chk("empty_cpu_rst_len", 32'(lowc), 32'd9);
    check_writes("empty");
    chk("empty_words", {16'd0, words_loaded}, 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("empty_halted", {31'd0, halted}, 32'd1);
    repeat (3) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("empty_halt_sticky", {31'd0, halted}, 32'd1);
    chk("empty_tn_halt", {31'd0, test_normal}, 32'd0);

    // Reset after the 3rd data byte: partial word discarded.
    do_reset();
    reset_n = 1'b1;
    wa.delete(); wd.delete();
    send_byte(8'h00, 1'b0);
    send_byte(8'h40, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b0);
    in_data  = 8'h78;
    reset_n  = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
    ea = '{16'h0040};
    ed = '{16'h1234};
    check_writes("abort");
    check_reset_values("abort");
    reset_n = 1'b1;
    tick();
    wa.delete(); wd.delete();
    stim = '{16'hBEEF};
    ea = '{16'h0050};
    ed = '{16'hBEEF};
    send_load(16'h0050, 1'b0);
    measure_cpu_rst(1'b0, lowc);
    check_writes("reload");
    chk("reload_words", {16'd0, words_loaded}, 32'd1);

    chk("single_cycle_we", 32'(long_pulse), 32'd0);
    chk("addr_data_hold", 32'(hold_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
